// File: rtl/router_ctrl_fsm_pkg.sv
// Shared types and constants for the 1x3 router control block.
package router_pkg;

  localparam int NUM_PORTS       = 3;
  localparam logic [1:0] ADDR_INVALID = 2'd3;
  localparam int TIMEOUT_DEFAULT = 30;

  typedef enum logic [2:0] {
    DECODE_ADDRESS,
    LOAD_FIRST_DATA,
    LOAD_DATA,
    LOAD_PARITY,
    CHECK_PARITY_ERROR,
    FIFO_FULL,
    LOAD_AFTER_FULL,
    WAIT_TILL_EMPTY
  } state_t;

endpackage

// File: rtl/router_ctrl_fsm_if.sv
// Handshake and status bundle between the router datapath/FIFOs and the control FSM.
interface router_ctrl_fsm_if;
  import router_pkg::*;

  logic                 pkt_valid;
  logic [1:0]           addr_in;
  logic                 parity_done;
  logic                 low_pkt_valid;
  logic                 fifo_full;
  logic [NUM_PORTS-1:0] fifo_empty;
  logic [NUM_PORTS-1:0] read_enb;
  logic                 busy;
  logic                 detect_add;
  logic                 lfd_state;
  logic                 ld_state;
  logic                 laf_state;
  logic                 full_state;
  logic                 rst_int_reg;
  logic [NUM_PORTS-1:0] write_enb;
  logic [NUM_PORTS-1:0] soft_rst;

  modport master (
    output pkt_valid, addr_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    input  busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb, soft_rst
  );

  modport slave (
    input  pkt_valid, addr_in, parity_done, low_pkt_valid, fifo_full, fifo_empty, read_enb,
    output busy, detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
           write_enb, soft_rst
  );

endinterface

// File: rtl/router_ctrl_fsm_soft_rst_timer.sv
// Per-port idle timer: pulses soft_rst_o for one cycle after TIMEOUT idle cycles on a non-empty FIFO.
module soft_rst_timer #(
  parameter int TIMEOUT = 30,
  parameter int CW      = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic empty,
  input  logic read_enb,
  output logic soft_rst_o
);

  logic [CW-1:0] count_q;

  // Clearing on the terminal count keeps the counter from ever wrapping.
  always_ff @(posedge clk) begin
    if (!rst) begin
      count_q    <= '0;
      soft_rst_o <= 1'b0;
    end else if (empty || read_enb) begin
      count_q    <= '0;
      soft_rst_o <= 1'b0;
    end else if (count_q == CW'(TIMEOUT - 1)) begin
      count_q    <= '0;
      soft_rst_o <= 1'b1;
    end else begin
      count_q    <= count_q + CW'(1);
      soft_rst_o <= 1'b0;
    end
  end

endmodule

// File: rtl/router_ctrl_fsm.sv
// Router control FSM: header decode, payload/parity load sequencing and per-port idle timeouts.
module router_ctrl_fsm
  import router_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CW      = 5
) (
  input  logic               clk,
  input  logic               rst,
  router_ctrl_fsm_if.slave   bus
);

  state_t               state_q, state_d;
  logic [1:0]           port_q, port_d;
  logic [NUM_PORTS-1:0] soft_rst_w;
  logic [3:0]           empty_ext;
  logic [3:0]           soft_ext;
  logic                 addr_ok;
  logic                 write_enb_reg;

  for (genvar i = 0; i < NUM_PORTS; i++) begin : gen_timer
    soft_rst_timer #(.TIMEOUT(TIMEOUT), .CW(CW)) u_timer (
      .clk        (clk),
      .rst        (rst),
      .empty      (bus.fifo_empty[i]),
      .read_enb   (bus.read_enb[i]),
      .soft_rst_o (soft_rst_w[i])
    );
  end

  assign bus.soft_rst = soft_rst_w;

  // Zero-extended so that a port index of 3 reads as "not empty / no reset".
  assign empty_ext = {1'b0, bus.fifo_empty};
  assign soft_ext  = {1'b0, soft_rst_w};
  assign addr_ok   = bus.pkt_valid && (bus.addr_in != ADDR_INVALID);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= DECODE_ADDRESS;
      port_q  <= 2'd0;
    end else begin
      state_q <= state_d;
      port_q  <= port_d;
    end
  end

  always_comb begin
    state_d = state_q;
    port_d  = port_q;
    case (state_q)
      DECODE_ADDRESS: begin
        if (addr_ok) begin
          port_d  = bus.addr_in;
          state_d = empty_ext[bus.addr_in] ? LOAD_FIRST_DATA : WAIT_TILL_EMPTY;
        end
      end
      WAIT_TILL_EMPTY:    if (empty_ext[port_q]) state_d = LOAD_FIRST_DATA;
      LOAD_FIRST_DATA:    state_d = LOAD_DATA;
      LOAD_DATA: begin
        if (bus.fifo_full)       state_d = FIFO_FULL;
        else if (!bus.pkt_valid) state_d = LOAD_PARITY;
      end
      LOAD_PARITY:        state_d = CHECK_PARITY_ERROR;
      CHECK_PARITY_ERROR: state_d = bus.fifo_full ? FIFO_FULL : DECODE_ADDRESS;
      FIFO_FULL:          if (!bus.fifo_full) state_d = LOAD_AFTER_FULL;
      LOAD_AFTER_FULL: begin
        if (bus.parity_done)        state_d = DECODE_ADDRESS;
        else if (bus.low_pkt_valid) state_d = LOAD_PARITY;
        else                        state_d = LOAD_DATA;
      end
      default:            state_d = DECODE_ADDRESS;
    endcase
    // A timed-out consumer abandons the packet in flight.
    if (state_q != DECODE_ADDRESS && soft_ext[port_q]) state_d = DECODE_ADDRESS;
  end

  always_comb begin
    bus.busy        = 1'b0;
    bus.detect_add  = 1'b0;
    bus.lfd_state   = 1'b0;
    bus.ld_state    = 1'b0;
    bus.laf_state   = 1'b0;
    bus.full_state  = 1'b0;
    bus.rst_int_reg = 1'b0;
    write_enb_reg   = 1'b0;
    case (state_q)
      DECODE_ADDRESS:     bus.detect_add = 1'b1;
      LOAD_FIRST_DATA: begin
        bus.busy      = 1'b1;
        bus.lfd_state = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_DATA: begin
        bus.ld_state  = 1'b1;
        write_enb_reg = 1'b1;
      end
      LOAD_PARITY: begin
        bus.busy      = 1'b1;
        write_enb_reg = 1'b1;
      end
      CHECK_PARITY_ERROR: begin
        bus.busy        = 1'b1;
        bus.rst_int_reg = 1'b1;
      end
      FIFO_FULL: begin
        bus.busy       = 1'b1;
        bus.full_state = 1'b1;
      end
      LOAD_AFTER_FULL: begin
        bus.busy      = 1'b1;
        bus.laf_state = 1'b1;
        write_enb_reg = 1'b1;
      end
      WAIT_TILL_EMPTY:    bus.busy = 1'b1;
      default:            bus.detect_add = 1'b1;
    endcase
    bus.write_enb = write_enb_reg ? (3'b001 << port_q) : 3'b000;
  end

endmodule

// File: tb/tb_router_ctrl_fsm.sv
// Directed self-checking bench for router_ctrl_fsm: packet flows, back-pressure, timeouts and reset.
module tb_router_ctrl_fsm;
  import router_pkg::*;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  router_ctrl_fsm_if bus();

  router_ctrl_fsm #(.TIMEOUT(30), .CW(5)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input state_t exp);
    check(tag, 8'(dut.state_q), 8'(exp));
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst               = 1'b0;
    bus.pkt_valid     = 1'b0;
    bus.addr_in       = 2'd0;
    bus.parity_done   = 1'b0;
    bus.low_pkt_valid = 1'b0;
    bus.fifo_full     = 1'b0;
    bus.fifo_empty    = 3'b111;
    bus.read_enb      = 3'b000;
    tick();
    tick();
    check_state("reset_state", DECODE_ADDRESS);
    check("reset_detect_add", 8'(bus.detect_add), 8'd1);
    check("reset_busy", 8'(bus.busy), 8'd0);
    check("reset_write_enb", 8'(bus.write_enb), 8'd0);
    check("reset_soft_rst", 8'(bus.soft_rst), 8'd0);
    rst = 1'b1;

    // Packet to port 1, all FIFOs empty
    bus.pkt_valid = 1'b1;
    bus.addr_in   = 2'd1;
    tick();
    check_state("p1_lfd", LOAD_FIRST_DATA);
    check("p1_lfd_flag", 8'(bus.lfd_state), 8'd1);
    check("p1_lfd_we", 8'(bus.write_enb), 8'b010);
    check("p1_lfd_busy", 8'(bus.busy), 8'd1);
    tick();
    check_state("p1_ld", LOAD_DATA);
    check("p1_ld_flag", 8'(bus.ld_state), 8'd1);
    check("p1_ld_busy", 8'(bus.busy), 8'd0);
    tick();
    tick();
    tick();
    check_state("p1_ld_hold", LOAD_DATA);
    check("p1_ld_we", 8'(bus.write_enb), 8'b010);
    bus.pkt_valid = 1'b0;
    tick();
    check_state("p1_lp", LOAD_PARITY);
    check("p1_lp_we", 8'(bus.write_enb), 8'b010);
    check("p1_lp_busy", 8'(bus.busy), 8'd1);
    tick();
    check_state("p1_cpe", CHECK_PARITY_ERROR);
    check("p1_cpe_rst_int", 8'(bus.rst_int_reg), 8'd1);
    check("p1_cpe_we", 8'(bus.write_enb), 8'd0);
    tick();
    check_state("p1_back_da", DECODE_ADDRESS);

    // Port 2 busy draining: wait, then load
    bus.fifo_empty = 3'b011;
    bus.read_enb   = 3'b100;
    bus.pkt_valid  = 1'b1;
    bus.addr_in    = 2'd2;
    tick();
    check_state("p2_wte", WAIT_TILL_EMPTY);
    check("p2_wte_busy", 8'(bus.busy), 8'd1);
    check("p2_wte_we", 8'(bus.write_enb), 8'd0);
    for (int i = 0; i < 4; i++) tick();
    check_state("p2_wte_hold", WAIT_TILL_EMPTY);
    bus.fifo_empty = 3'b111;
    bus.read_enb   = 3'b000;
    tick();
    check_state("p2_lfd", LOAD_FIRST_DATA);
    check("p2_lfd_we", 8'(bus.write_enb), 8'b100);
    tick();
    check_state("p2_ld", LOAD_DATA);

    // Back-pressure: full has priority over pkt_valid low
    bus.fifo_full = 1'b1;
    bus.pkt_valid = 1'b0;
    tick();
    check_state("ffs_enter", FIFO_FULL);
    check("ffs_full_state", 8'(bus.full_state), 8'd1);
    check("ffs_busy", 8'(bus.busy), 8'd1);
    check("ffs_we", 8'(bus.write_enb), 8'd0);
    tick();
    tick();
    check_state("ffs_hold", FIFO_FULL);
    bus.fifo_full = 1'b0;
    tick();
    check_state("laf_enter", LOAD_AFTER_FULL);
    check("laf_flag", 8'(bus.laf_state), 8'd1);
    check("laf_we", 8'(bus.write_enb), 8'b100);
    bus.low_pkt_valid = 1'b1;
    tick();
    check_state("laf_to_lp", LOAD_PARITY);
    bus.low_pkt_valid = 1'b0;
    tick();
    check_state("laf_lp_cpe", CHECK_PARITY_ERROR);
    tick();
    check_state("laf_lp_da", DECODE_ADDRESS);

    bus.pkt_valid = 1'b1;
    tick();
    tick();
    check_state("rep_ld", LOAD_DATA);
    bus.fifo_full = 1'b1;
    tick();
    bus.fifo_full = 1'b0;
    tick();
    check_state("rep_laf", LOAD_AFTER_FULL);
    tick();
    check_state("laf_to_ld", LOAD_DATA);
    bus.fifo_full = 1'b1;
    tick();
    bus.fifo_full = 1'b0;
    tick();
    bus.parity_done = 1'b1;
    bus.pkt_valid   = 1'b0;
    tick();
    check_state("laf_to_da", DECODE_ADDRESS);
    bus.parity_done = 1'b0;

    // Idle timer on port 0: pulse on the 30th idle cycle only
    bus.fifo_empty = 3'b110;
    for (int n = 1; n <= 31; n++) begin
      tick();
      check($sformatf("tmr0_n%0d", n), 8'(bus.soft_rst), (n == 30) ? 8'b001 : 8'b000);
    end
    check_state("tmr0_da_unaffected", DECODE_ADDRESS);
    bus.fifo_empty = 3'b111;
    tick();

    // A read at idle cycle 20 restarts the count
    bus.fifo_empty = 3'b110;
    for (int n = 1; n <= 19; n++) tick();
    bus.read_enb = 3'b001;
    tick();
    bus.read_enb = 3'b000;
    for (int m = 1; m <= 30; m++) begin
      tick();
      if (m == 10 || m >= 29)
        check($sformatf("tmr0_read_m%0d", m), 8'(bus.soft_rst), (m == 30) ? 8'b001 : 8'b000);
    end
    bus.fifo_empty = 3'b111;
    tick();

    // Timeout aborts a packet to port 0 in LOAD_DATA
    bus.pkt_valid = 1'b1;
    bus.addr_in   = 2'd0;
    tick();
    tick();
    check_state("abort_ld", LOAD_DATA);
    bus.fifo_empty = 3'b110;
    for (int n = 1; n <= 30; n++) tick();
    check("abort_pulse", 8'(bus.soft_rst), 8'b001);
    check_state("abort_pre", LOAD_DATA);
    bus.pkt_valid = 1'b0;
    tick();
    check_state("abort_da", DECODE_ADDRESS);
    check("abort_we", 8'(bus.write_enb), 8'd0);
    check("abort_pulse_end", 8'(bus.soft_rst), 8'd0);
    bus.fifo_empty = 3'b111;

    // Invalid address is dropped and does not move port_q
    bus.pkt_valid = 1'b1;
    bus.addr_in   = 2'd3;
    tick();
    tick();
    check_state("inv_addr_da", DECODE_ADDRESS);
    check("inv_addr_detect", 8'(bus.detect_add), 8'd1);
    check("inv_addr_port", 8'(dut.port_q), 8'd0);

    // Reset mid-packet while in FIFO_FULL
    bus.fifo_empty = 3'b011;
    bus.addr_in    = 2'd1;
    tick();
    tick();
    bus.fifo_full = 1'b1;
    tick();
    check_state("rst_ffs", FIFO_FULL);
    check("rst_tmr2_running", 8'(dut.gen_timer[2].u_timer.count_q), 8'd3);
    rst = 1'b0;
    tick();
    check_state("rst_da", DECODE_ADDRESS);
    check("rst_detect", 8'(bus.detect_add), 8'd1);
    check("rst_soft", 8'(bus.soft_rst), 8'd0);
    check("rst_tmr0", 8'(dut.gen_timer[0].u_timer.count_q), 8'd0);
    check("rst_tmr1", 8'(dut.gen_timer[1].u_timer.count_q), 8'd0);
    check("rst_tmr2", 8'(dut.gen_timer[2].u_timer.count_q), 8'd0);
    check("rst_port", 8'(dut.port_q), 8'd0);
    rst = 1'b1;
    bus.fifo_full = 1'b0;
    bus.pkt_valid = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
